// File: rtl/dyt_fetch_stage.sv
// -----------------------------------------------------------------------------
// dyt_fetch_stage
//   Instruction fetch stage. Owns the PC, issues word reads to instruction
//   memory over a req/ready handshake, and drives the IF/ID latch inputs.
//   It honours decode stall, branch/jump redirect (flush) and halt. When memory
//   returns a word while decode is stalled, that word is parked in a one-entry
//   skid buffer so the request does not have to be repeated.
//
// Parameters
//   RESET_PC   PC loaded on reset
//   NOP_INSTR  instruction presented on IF/ID whenever it is not valid
//
// Ports
//   CLK                 in   1   clock, rising edge
//   nRST                in   1   synchronous reset, active low
//   imem_req_o          out  1   instruction read request
//   imem_addr_o         out  32  read address (always word aligned)
//   imem_ready_i        in   1   imem_rdata_i valid for the current request
//   imem_rdata_i        in   32  fetched instruction word
//   stall_i             in   1   IF/ID must hold its contents this cycle
//   redirect_i          in   1   branch/jump taken; flush and refetch
//   redirect_pc_i       in   32  new PC; bits [1:0] forced to zero
//   halt_i              in   1   halt decoded downstream; stop fetching
//   ifid_instruction_o  out  32  instruction to IF/ID latch
//   ifid_pc_o           out  32  PC of ifid_instruction_o
//   ifid_valid_o        out  1   IF/ID contents are a real instruction
//   halted_o            out  1   fetch halted (sticky until reset)
// -----------------------------------------------------------------------------
module dyt_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        halt_i,
  output logic [31:0] ifid_instruction_o,
  output logic [31:0] ifid_pc_o,
  output logic        ifid_valid_o,
  output logic        halted_o
);

  typedef enum logic [1:0] {
    IDLE,   // one dead cycle out of reset
    FETCH,  // request outstanding at pc_q
    HOLD,   // skid buffer full, waiting for decode to unstall
    HALT    // fetch stopped until reset
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] skid_instr_q;
  logic [31:0] skid_pc_q;
  logic        skid_load;

  assign imem_req_o  = (state_q == FETCH);
  assign imem_addr_o = pc_q;

  // A word arrives while decode is stalled and nothing of higher priority
  // (reset, halt, redirect) discards it.
  assign skid_load = nRST && (state_q == FETCH) && imem_ready_i && stall_i &&
                     !redirect_i && !halt_i;

  // NOTE: the skid entry is only ever read in HOLD, which is entered on the
  // same edge that loads it, so its storage needs no reset; "empty" is simply
  // state_q != HOLD.
  always_ff @(posedge CLK) begin
    if (skid_load) begin
      skid_instr_q <= imem_rdata_i;
      skid_pc_q    <= pc_q;
    end
  end

  // NOTE: every register below is assigned with <= so all of them see the
  // pre-edge values of pc_q and state_q, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q            <= IDLE;
      pc_q               <= RESET_PC;
      ifid_valid_o       <= 1'b0;
      ifid_instruction_o <= NOP_INSTR;
      ifid_pc_o          <= 32'h0000_0000;
      halted_o           <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= FETCH;

        HALT: state_q <= HALT;

        FETCH, HOLD: begin
          if (halt_i) begin
            state_q            <= HALT;
            halted_o           <= 1'b1;
            ifid_valid_o       <= 1'b0;
            ifid_instruction_o <= NOP_INSTR;
          end else if (redirect_i) begin
            // Flush wins over stall: IF/ID is squashed even if decode holds.
            state_q            <= FETCH;
            pc_q               <= redirect_pc_i & ~32'h0000_0003;
            ifid_valid_o       <= 1'b0;
            ifid_instruction_o <= NOP_INSTR;
          end else if (state_q == HOLD) begin
            if (!stall_i) begin
              state_q            <= FETCH;
              ifid_valid_o       <= 1'b1;
              ifid_instruction_o <= skid_instr_q;
              ifid_pc_o          <= skid_pc_q;
            end
          end else if (imem_ready_i) begin
            // Accepted word: the PC advances whether it lands in IF/ID or skid.
            pc_q <= pc_q + 32'd4;
            if (stall_i) begin
              state_q <= HOLD;
            end else begin
              ifid_valid_o       <= 1'b1;
              ifid_instruction_o <= imem_rdata_i;
              ifid_pc_o          <= pc_q;
            end
          end else if (!stall_i) begin
            // Memory wait with decode free: insert a bubble, keep the old PC tag.
            ifid_valid_o       <= 1'b0;
            ifid_instruction_o <= NOP_INSTR;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
